// File: rtl/tick_event_queue.sv
// Pending-event counter between a tick generator and a slow consumer.
// Ticks increment the count and acks drain it; o_OVF reports ticks dropped while the count is full.
module tick_event_queue #(
  parameter int CNT_W      = 4,
  parameter bit OVF_STICKY = 1'b1
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_TICK,
  input  logic             i_ACK,
  input  logic             i_CLR_OVF,
  output logic             o_VALID,
  output logic [CNT_W-1:0] o_COUNT,
  output logic             o_FULL,
  output logic             o_OVF
);

  // Handshake: an event is consumed on a rising edge where o_VALID=1 and i_ACK=1.
  // i_ACK while o_VALID=0 has no effect.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MAX_M1 = MAX - ONE;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_valid;
  logic             r_full;
  logic             r_ovf;
  logic             w_inc;
  logic             w_dec;
  logic             w_drop;

  assign w_inc = i_TICK;
  assign w_dec = r_valid & i_ACK;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_state_nxt != ST_EMPTY);
      r_full  <= (w_state_nxt == ST_FULL);
      // Sticky mode: a drop in the same cycle as a clear keeps the flag set.
      r_ovf   <= OVF_STICKY ? (w_drop | (r_ovf & ~i_CLR_OVF)) : w_drop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_drop      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_inc) begin
          w_count_nxt = ONE;
          w_state_nxt = (MAX == ONE) ? ST_FULL : ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_inc && !w_dec) begin
          w_count_nxt = r_count + ONE;
          w_state_nxt = (r_count == MAX_M1) ? ST_FULL : ST_PEND;
        end else if (w_dec && !w_inc) begin
          w_count_nxt = r_count - ONE;
          w_state_nxt = (r_count == ONE) ? ST_EMPTY : ST_PEND;
        end
      end
      ST_FULL: begin
        if (w_inc && !w_dec) begin
          w_drop = 1'b1;
        end else if (w_dec && !w_inc) begin
          w_count_nxt = r_count - ONE;
          w_state_nxt = (r_count == ONE) ? ST_EMPTY : ST_PEND;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_count_nxt = '0;
      end
    endcase
  end

  assign o_VALID = r_valid;
  assign o_COUNT = r_count;
  assign o_FULL  = r_full;
  assign o_OVF   = r_ovf;

endmodule

// File: tb/tb_tick_event_queue.sv
// Bench for tick_event_queue: three instances (4-bit sticky, 2-bit pulse, 1-bit sticky)
// checked every cycle against a counting model, plus directed literal expectations.
module tb_tick_event_queue;

  logic clk;
  logic rst;
  logic tick [3];
  logic ack  [3];
  logic clr  [3];
  logic valid[3];
  logic full [3];
  logic ovf  [3];
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;
  logic [0:0] cnt_c;

  int checks;
  int errors;
  int m_count[3];
  bit m_ovf  [3];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
    errors = errors + 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  tick_event_queue #(.CNT_W(4), .OVF_STICKY(1'b1)) u_a (
    .i_CLK(clk), .i_RST(rst), .i_TICK(tick[0]), .i_ACK(ack[0]), .i_CLR_OVF(clr[0]),
    .o_VALID(valid[0]), .o_COUNT(cnt_a), .o_FULL(full[0]), .o_OVF(ovf[0]));

  tick_event_queue #(.CNT_W(2), .OVF_STICKY(1'b0)) u_b (
    .i_CLK(clk), .i_RST(rst), .i_TICK(tick[1]), .i_ACK(ack[1]), .i_CLR_OVF(clr[1]),
    .o_VALID(valid[1]), .o_COUNT(cnt_b), .o_FULL(full[1]), .o_OVF(ovf[1]));

  tick_event_queue #(.CNT_W(1), .OVF_STICKY(1'b1)) u_c (
    .i_CLK(clk), .i_RST(rst), .i_TICK(tick[2]), .i_ACK(ack[2]), .i_CLR_OVF(clr[2]),
    .o_VALID(valid[2]), .o_COUNT(cnt_c), .o_FULL(full[2]), .o_OVF(ovf[2]));

  function automatic int max_of(input int i);
    if (i == 0) return 15;
    if (i == 1) return 3;
    return 1;
  endfunction

  function automatic bit sticky_of(input int i);
    return (i != 1);
  endfunction

  function automatic int dut_count(input int i);
    if (i == 0) return int'(cnt_a);
    if (i == 1) return int'(cnt_b);
    return int'(cnt_c);
  endfunction

  // ---------------- behavioural model ----------------
  always @(posedge clk or posedge rst) begin
    bit inc;
    bit dec;
    bit drop;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_count[i] <= 0;
        m_ovf[i]   <= 1'b0;
      end else begin
        inc  = tick[i];
        dec  = (m_count[i] != 0) && ack[i];
        drop = inc && !dec && (m_count[i] == max_of(i));
        if (inc && !dec && !drop) m_count[i] <= m_count[i] + 1;
        else if (dec && !inc)     m_count[i] <= m_count[i] - 1;
        if (sticky_of(i)) m_ovf[i] <= drop ? 1'b1 : (clr[i] ? 1'b0 : m_ovf[i]);
        else              m_ovf[i] <= drop;
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  task automatic check_val(input string name, input int idx, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s[%0d] t=%0t act=%0d req=%0d", name, idx, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val("cmp_count", i, dut_count(i), m_count[i]);
      check_val("cmp_valid", i, int'(valid[i]), int'(m_count[i] != 0));
      check_val("cmp_full",  i, int'(full[i]),  int'(m_count[i] == max_of(i)));
      check_val("cmp_ovf",   i, int'(ovf[i]),   int'(m_ovf[i]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      tick[i] = 1'b0;
      ack[i]  = 1'b0;
      clr[i]  = 1'b0;
    end
  endtask

  // Drive one instance for one cycle (inputs change on the falling edge),
  // return 1 time unit after the rising edge that sampled them.
  task automatic step(input int i, input bit t, input bit a, input bit c);
    @(negedge clk);
    idle_all();
    tick[i] = t;
    ack[i]  = a;
    clr[i]  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    check_val(name, 0, act, exp);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      m_count[i] = 0;
      m_ovf[i]   = 1'b0;
    end
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("rst_count", int'(cnt_a), 0);
    lit("rst_valid", int'(valid[0]), 0);
    lit("rst_ovf",   int'(ovf[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    // single tick then single ack
    step(0, 1, 0, 0);
    lit("tick1_count", int'(cnt_a), 1);
    lit("tick1_valid", int'(valid[0]), 1);
    step(0, 0, 1, 0);
    lit("ack1_count", int'(cnt_a), 0);
    lit("ack1_valid", int'(valid[0]), 0);

    // fill to MAX, then overflow, then clear
    repeat (15) step(0, 1, 0, 0);
    lit("fill_count", int'(cnt_a), 15);
    lit("fill_full",  int'(full[0]), 1);
    lit("fill_ovf",   int'(ovf[0]), 0);
    step(0, 1, 0, 0);
    lit("drop_count", int'(cnt_a), 15);
    lit("drop_ovf",   int'(ovf[0]), 1);
    step(0, 0, 0, 0);
    lit("drop_ovf_hold", int'(ovf[0]), 1);
    step(0, 0, 0, 1);
    lit("clr_ovf", int'(ovf[0]), 0);

    // simultaneous tick+ack at MAX and mid-range
    step(0, 1, 1, 0);
    lit("simul_max_count", int'(cnt_a), 15);
    lit("simul_max_ovf",   int'(ovf[0]), 0);
    repeat (12) step(0, 0, 1, 0);
    lit("drain_to3", int'(cnt_a), 3);
    step(0, 1, 1, 0);
    lit("simul_mid_count", int'(cnt_a), 3);
    repeat (3) step(0, 0, 1, 0);

    // ack with nothing pending: no underflow
    repeat (5) step(0, 0, 1, 0);
    lit("no_underflow", int'(cnt_a), 0);
    repeat (4) step(0, 1, 0, 0);
    lit("refill4", int'(cnt_a), 4);
    step(0, 0, 1, 0);
    lit("drain_3", int'(cnt_a), 3);
    step(0, 0, 1, 0);
    lit("drain_2", int'(cnt_a), 2);
    step(0, 0, 1, 0);
    lit("drain_1", int'(cnt_a), 1);
    lit("drain_1_valid", int'(valid[0]), 1);
    step(0, 0, 1, 0);
    lit("drain_0", int'(cnt_a), 0);
    lit("drain_0_valid", int'(valid[0]), 0);

    // drop and clear in the same cycle: set wins
    repeat (15) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    lit("set_wins_ovf", int'(ovf[0]), 1);
    step(0, 0, 0, 1);
    lit("set_wins_clr", int'(ovf[0]), 0);
    repeat (6) step(0, 0, 1, 0);
    lit("pre_rst_count", int'(cnt_a), 9);

    // async reset mid-cycle with ack high
    @(negedge clk);
    idle_all();
    ack[0] = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    lit("async_rst_count", int'(cnt_a), 0);
    lit("async_rst_valid", int'(valid[0]), 0);
    lit("async_rst_full",  int'(full[0]), 0);
    lit("async_rst_ovf",   int'(ovf[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    step(0, 1, 0, 0);
    lit("post_rst_tick", int'(cnt_a), 1);

    // pulse-mode overflow on the 2-bit instance
    repeat (3) step(1, 1, 0, 0);
    lit("b_fill_count", int'(cnt_b), 3);
    lit("b_fill_ovf",   int'(ovf[1]), 0);
    step(1, 1, 0, 0);
    lit("b_tick4_ovf", int'(ovf[1]), 1);
    step(1, 1, 0, 0);
    lit("b_tick5_ovf",   int'(ovf[1]), 1);
    lit("b_tick5_count", int'(cnt_b), 3);
    step(1, 0, 0, 0);
    lit("b_ovf_clear", int'(ovf[1]), 0);

    // 1-bit instance: EMPTY <-> FULL directly
    step(2, 1, 0, 0);
    lit("c_full", int'(full[2]), 1);
    step(2, 0, 1, 0);
    lit("c_empty", int'(valid[2]), 0);

    // randomized phase on all three instances
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        tick[i] = ($urandom_range(99) < 55);
        ack[i]  = ($urandom_range(99) < 45);
        clr[i]  = ($urandom_range(99) < 10);
      end
      if ($urandom_range(399) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
    end
    @(negedge clk);
    idle_all();
    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_event_queue.md
Name: tick_event_queue

Overview:
Receives single-cycle tick pulses from a button tick generator and holds them as a pending-event count. A slow consumer, such as the SSD1331 draw/command sequencer, drains the count one event at a time through a valid/ack handshake. Ticks that arrive while the consumer is busy are therefore not lost. Sits between the button edge-detect stage and the OLED control FSM; one instance per button.

Parameters:
CNT_W, 4, width of pending-event counter; capacity MAX = 2^CNT_W - 1 events (CNT_W >= 1)
OVF_STICKY, 1, 1 = o_OVF holds until i_CLR_OVF; 0 = o_OVF is a one-cycle pulse per dropped tick

Ports:
i_CLK  input  1  system clock; all state updates on rising edge
i_RST  input  1  reset, asynchronous, active-high
i_TICK  input  1  event strike from tick generator; each high cycle = one event
i_ACK  input  1  consumer accepts one event; meaningful only while o_VALID=1
i_CLR_OVF  input  1  clears sticky overflow flag (ignored when OVF_STICKY=0)
o_VALID  output  1  registered; 1 when pending count != 0
o_COUNT  output  CNT_W  registered pending-event count
o_FULL  output  1  registered; 1 when count == MAX
o_OVF  output  1  registered overflow indicator

Behaviour:
- Reset (async assert, any time, including mid-handshake): count=0, o_VALID=0, o_FULL=0, o_OVF=0, state=EMPTY. Pending events are discarded.
- The tick source updates on the falling edge of i_CLK. This block samples i_TICK on the rising edge, half a cycle later. No synchronizer is required.
- Per rising edge: inc = i_TICK; dec = o_VALID & i_ACK. i_ACK while o_VALID=0 is ignored: no underflow, no error.
- Count update rules:
  - inc & ~dec: count+1, unless count==MAX, in which case the tick is dropped and overflow is flagged.
  - ~inc & dec: count-1.
  - inc & dec: count unchanged, including at MAX. This is not an overflow, because the slot frees in the same cycle.
  - Neither: hold.
- State machine, with encoding derived from count and outputs registered:
  - EMPTY (count=0) -> PEND on inc.
  - PEND (0<count<MAX):
    - -> EMPTY on dec & ~inc when count==1.
    - -> FULL on inc & ~dec when count==MAX-1.
    - Otherwise stays in PEND.
  - FULL (count=MAX):
    - -> PEND on dec & ~inc.
    - Stays in FULL on inc & ~dec, which is the drop/overflow case.
  - CNT_W=1 special case: PEND is unreachable; EMPTY<->FULL directly.
- Latency:
  - A tick sampled at edge N makes o_VALID=1 and updates o_COUNT after edge N.
  - An ack sampled at edge N updates o_COUNT after edge N.
  - One event is consumed per ack cycle; holding i_ACK high drains one event per clock.
- Overflow:
  - OVF_STICKY=1: o_OVF sets on the drop cycle and holds until i_CLR_OVF. If i_CLR_OVF and a new drop occur in the same cycle, set wins.
  - OVF_STICKY=0: o_OVF is high for exactly the cycle after each drop.
- Outputs are glitch-free registers. o_VALID, o_FULL and o_COUNT are mutually consistent every cycle.

Test Plan:
- Reset, then a 1-cycle i_TICK -> o_VALID=1, o_COUNT=1 after that edge; i_ACK 1 cycle -> o_COUNT=0, o_VALID=0.
- CNT_W=4: 15 consecutive tick cycles, no ack -> o_COUNT=15, o_FULL=1, o_OVF=0; 16th tick -> o_COUNT=15, o_OVF=1 (sticky); i_CLR_OVF -> o_OVF=0.
- At count=15, i_TICK and i_ACK in the same cycle -> o_COUNT stays 15, o_OVF stays 0; at count=3, simultaneous -> stays 3.
- i_ACK held high with count=0 for 5 cycles -> o_COUNT stays 0, no underflow to 15; then count=4 with i_ACK held -> drains 4,3,2,1,0 on consecutive edges, o_VALID drops after the 4th.
- i_RST asserted asynchronously mid-cycle at count=9 with i_ACK high -> all outputs 0 immediately, before the next clock edge; first tick after release -> o_COUNT=1.
- OVF_STICKY=0, CNT_W=2: 5 ticks with no ack -> o_COUNT=3; o_OVF pulses high for 1 cycle after each of the 4th and 5th ticks, then returns to 0.
